// File: rtl/mul_share_ctrl_if.sv
// Bundle of request, response and multiplier-datapath signals for mul_share_ctrl.
// The slave modport is the controller; the master modport is the requester/multiplier side.
interface mul_share_ctrl_if #(
  parameter int N = 16
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [N-1:0] rsp0_p;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [N-1:0] rsp1_p;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic [N-1:0] mul_p;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    input  rsp0_ready,
    output rsp0_valid, rsp0_p,
    input  rsp1_ready,
    output rsp1_valid, rsp1_p,
    output mul_a, mul_b,
    input  mul_p,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    output rsp0_ready,
    input  rsp0_valid, rsp0_p,
    output rsp1_ready,
    input  rsp1_valid, rsp1_p,
    input  mul_a, mul_b,
    output mul_p,
    input  busy
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Two-port round-robin sequencer sharing one combinational multiplier: registers operands,
// waits MUL_LAT cycles, captures the product and returns it on the granted port's response channel.
module mul_share_ctrl #(
  parameter int N       = 16,
  parameter int MUL_LAT = 1
) (
  input logic            clk,
  input logic            rst_n,
  mul_share_ctrl_if.slave bus
);

  localparam int         LAT_EFF = (MUL_LAT < 1) ? 1 : ((MUL_LAT > 15) ? 15 : MUL_LAT);
  localparam logic [3:0] LAT_CNT = 4'(LAT_EFF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_last_grant;
  logic         r_tag;
  logic [3:0]   r_cnt;
  logic [N-1:0] r_mul_a;
  logic [N-1:0] r_mul_b;
  logic [N-1:0] r_result;
  logic         r_rsp0_valid;
  logic         r_rsp1_valid;
  logic         r_busy;

  logic         w_grant0;
  logic         w_grant1;
  logic         w_ready0;
  logic         w_ready1;
  logic         w_rsp_hs;

  // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant0 = bus.req0_valid;
      w_grant1 = bus.req1_valid;
    end
  end

  assign w_ready0 = rst_n & (r_state == S_IDLE) & w_grant0;
  assign w_ready1 = rst_n & (r_state == S_IDLE) & w_grant1;
  // Only the tagged port's ready can complete a response.
  assign w_rsp_hs = r_tag ? bus.rsp1_ready : bus.rsp0_ready;

  // Operation sequencer: accept, settle for LAT_CNT cycles, hold the result until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_tag        <= 1'b0;
      r_cnt        <= 4'd0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_result     <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ready0) begin
            r_mul_a      <= bus.req0_a;
            r_mul_b      <= bus.req0_b;
            r_tag        <= 1'b0;
            r_last_grant <= 1'b0;
            r_cnt        <= LAT_CNT;
            r_busy       <= 1'b1;
            r_state      <= S_CALC;
          end else if (w_ready1) begin
            r_mul_a      <= bus.req1_a;
            r_mul_b      <= bus.req1_b;
            r_tag        <= 1'b1;
            r_last_grant <= 1'b1;
            r_cnt        <= LAT_CNT;
            r_busy       <= 1'b1;
            r_state      <= S_CALC;
          end else begin
            r_busy       <= 1'b0;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_result     <= bus.mul_p;
            r_rsp0_valid <= ~r_tag;
            r_rsp1_valid <= r_tag;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp0_valid = rst_n & r_rsp0_valid;
  assign bus.rsp1_valid = rst_n & r_rsp1_valid;
  assign bus.rsp0_p     = r_result;
  assign bus.rsp1_p     = r_result;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.busy       = rst_n & r_busy;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: three instances (MUL_LAT 1, 4, 0), directed steps
// plus randomized traffic checked against a transaction-level reference model.
module tb_mul_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v0 [3];
  logic        v1 [3];
  logic        rr0 [3];
  logic        rr1 [3];
  logic [15:0] a0 [3];
  logic [15:0] b0 [3];
  logic [15:0] a1 [3];
  logic [15:0] b1 [3];
  logic        rd0 [3];
  logic        rd1 [3];
  logic        rv0 [3];
  logic        rv1 [3];
  logic        bsy [3];
  logic [15:0] p0 [3];
  logic [15:0] p1 [3];
  logic [15:0] ma [3];
  logic [15:0] mb [3];

  int n_tests = 0;
  int n_fail  = 0;

  mul_share_ctrl_if #(.N(16)) bus [3] ();

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign bus[k].req0_valid = v0[k];
    assign bus[k].req0_a     = a0[k];
    assign bus[k].req0_b     = b0[k];
    assign bus[k].req1_valid = v1[k];
    assign bus[k].req1_a     = a1[k];
    assign bus[k].req1_b     = b1[k];
    assign bus[k].rsp0_ready = rr0[k];
    assign bus[k].rsp1_ready = rr1[k];
    assign bus[k].mul_p      = bus[k].mul_a * bus[k].mul_b;
    assign rd0[k] = bus[k].req0_ready;
    assign rd1[k] = bus[k].req1_ready;
    assign rv0[k] = bus[k].rsp0_valid;
    assign rv1[k] = bus[k].rsp1_valid;
    assign p0[k]  = bus[k].rsp0_p;
    assign p1[k]  = bus[k].rsp1_p;
    assign ma[k]  = bus[k].mul_a;
    assign mb[k]  = bus[k].mul_b;
    assign bsy[k] = bus[k].busy;

    mul_share_ctrl #(
      .N       (16),
      .MUL_LAT ((k == 0) ? 1 : ((k == 1) ? 4 : 0))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (inputs change here).
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge where outputs are sampled.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin
      v0[k] = 1'b0; v1[k] = 1'b0; rr0[k] = 1'b1; rr1[k] = 1'b1;
      a0[k] = 16'h0; b0[k] = 16'h0; a1[k] = 16'h0; b1[k] = 16'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int k);
    int c;
    c = 0;
    smp();
    while (bsy[k] !== 1'b0 && c < 60) begin
      nxt(); smp(); c++;
    end
    chk("drain_timeout", {31'd0, c < 60}, 32'd1);
    nxt();
  endtask

  // One operation on instance k, port prt, response ready held high.
  task automatic run_op(input int k, input bit prt, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input int lat, input string tag);
    int c;
    rr0[k] = 1'b1; rr1[k] = 1'b1;
    if (prt) begin v1[k] = 1'b1; a1[k] = a; b1[k] = b; end
    else     begin v0[k] = 1'b1; a0[k] = a; b0[k] = b; end
    smp();
    chk({tag, "_ready"}, {30'd0, rd1[k], rd0[k]}, prt ? 32'd2 : 32'd1);
    nxt();
    v0[k] = 1'b0; v1[k] = 1'b0;
    a0[k] = 16'($urandom); a1[k] = 16'($urandom);
    c = 1;
    smp();
    while (!(rv0[k] || rv1[k]) && c < 40) begin
      chk({tag, "_mul_hold"}, {ma[k], mb[k]}, {a, b});
      nxt(); smp(); c++;
    end
    chk({tag, "_latency"}, 32'(c), 32'(lat + 1));
    chk({tag, "_rsp_p"}, {16'd0, prt ? p1[k] : p0[k]}, {16'd0, exp});
    chk({tag, "_other_valid"}, {31'd0, prt ? rv0[k] : rv1[k]}, 32'd0);
    nxt(); smp();
    chk({tag, "_done"}, {30'd0, bsy[k], prt ? rv1[k] : rv0[k]}, 32'd0);
    nxt();
  endtask

  // Random traffic on instance k against a timestamp-based transaction model.
  task automatic rand_run(input int k, input int lat, input int ncyc);
    bit          m_busy;
    bit          m_port;
    bit          m_last;
    int          m_rsp_at;
    logic [15:0] m_prod;
    bit          win0, win1, in_resp, taken;
    logic [31:0] full;
    m_busy = 1'b0; m_port = 1'b0; m_last = 1'b1; m_rsp_at = 0; m_prod = 16'h0;
    for (int c = 0; c < ncyc; c++) begin
      v0[k]  = ($urandom_range(0, 2) != 0);
      v1[k]  = ($urandom_range(0, 2) != 0);
      rr0[k] = ($urandom_range(0, 3) != 0);
      rr1[k] = ($urandom_range(0, 3) != 0);
      a0[k] = 16'($urandom); b0[k] = 16'($urandom);
      a1[k] = 16'($urandom); b1[k] = 16'($urandom);
      smp();
      win0 = 1'b0; win1 = 1'b0;
      if (!m_busy) begin
        if (v0[k] && v1[k]) begin
          if (m_last) win0 = 1'b1; else win1 = 1'b1;
        end else begin
          win0 = v0[k];
          win1 = v1[k];
        end
      end
      in_resp = m_busy && (c >= m_rsp_at);
      chk("rnd_ready", {30'd0, rd1[k], rd0[k]}, {30'd0, win1, win0});
      chk("rnd_busy", {31'd0, bsy[k]}, {31'd0, m_busy});
      chk("rnd_rsp_valid", {30'd0, rv1[k], rv0[k]},
          {30'd0, in_resp && m_port, in_resp && !m_port});
      if (in_resp) chk("rnd_rsp_p", {16'd0, m_port ? p1[k] : p0[k]}, {16'd0, m_prod});
      taken = m_port ? rr1[k] : rr0[k];
      if (in_resp && taken) begin
        m_busy = 1'b0;
      end else if (win0 || win1) begin
        m_busy   = 1'b1;
        m_port   = win1;
        m_last   = win1;
        full     = win1 ? (32'(a1[k]) * 32'(b1[k])) : (32'(a0[k]) * 32'(b0[k]));
        m_prod   = 16'(full % 32'h10000);
        m_rsp_at = c + lat + 1;
      end
      nxt();
    end
    v0[k] = 1'b0; v1[k] = 1'b0; rr0[k] = 1'b1; rr1[k] = 1'b1;
    wait_idle(k);
  endtask

  initial begin : main
    int c, nacc, nrsp, last_acc, acc_port;
    logic [15:0] held;

    idle_inputs();
    rst_n = 1'b0;
    v0[0] = 1'b1;
    nxt();
    smp();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {30'd0, rd1[k], rd0[k]}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rv1[k], rv0[k]}, 32'd0);
      chk("rst_busy", {31'd0, bsy[k]}, 32'd0);
      chk("rst_rsp_p", {p1[k], p0[k]}, 32'd0);
      chk("rst_mul_ab", {ma[k], mb[k]}, 32'd0);
    end
    nxt();
    v0[0] = 1'b0;
    rst_n = 1'b1;
    nxt();

    // Single op on port 0, MUL_LAT=1.
    v0[0] = 1'b1; a0[0] = 16'd3; b0[0] = 16'd5;
    smp();
    chk("single_ready", {30'd0, rd1[0], rd0[0]}, 32'd1);
    nxt();
    v0[0] = 1'b0;
    smp();
    chk("single_c1", {29'd0, bsy[0], rv1[0], rv0[0]}, 32'd4);
    chk("single_mul_ab", {ma[0], mb[0]}, {16'd3, 16'd5});
    nxt(); smp();
    chk("single_c2_valid", {30'd0, rv1[0], rv0[0]}, 32'd1);
    chk("single_c2_p", {16'd0, p0[0]}, 32'h000F);
    nxt(); smp();
    chk("single_c3", {29'd0, bsy[0], rv1[0], rv0[0]}, 32'd0);
    nxt();

    run_op(0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 1, "trunc1");
    run_op(0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 1, "trunc0");
    run_op(1, 1'b0, 16'h1234, 16'h0002, 16'h2468, 4, "lat4");
    run_op(2, 1'b0, 16'h1234, 16'h0002, 16'h2468, 1, "lat0");
    run_op(2, 1'b1, 16'h00FF, 16'h0101, 16'hFFFF, 1, "lat0_p1");

    // Back-pressure on port 0 with port 1 waiting and asserting its own rsp_ready.
    rr0[0] = 1'b0;
    v0[0] = 1'b1; a0[0] = 16'h0011; b0[0] = 16'h0003;
    smp();
    chk("bp_accept", {30'd0, rd1[0], rd0[0]}, 32'd1);
    nxt();
    v0[0] = 1'b0;
    c = 0;
    smp();
    while (rv0[0] !== 1'b1 && c < 20) begin nxt(); smp(); c++; end
    chk("bp_rsp_timeout", {31'd0, c < 20}, 32'd1);
    held = p0[0];
    chk("bp_rsp_p", {16'd0, held}, 32'h0033);
    nxt();
    for (int i = 0; i < 10; i++) begin
      v0[0] = 1'b1; v1[0] = 1'b1; rr1[0] = 1'b1;
      a1[0] = 16'd7; b1[0] = 16'd9;
      smp();
      chk("bp_hold", {27'd0, bsy[0], rd1[0], rd0[0], rv1[0], rv0[0]}, 32'b10001);
      chk("bp_hold_p", {16'd0, p0[0]}, {16'd0, held});
      nxt();
    end
    rr0[0] = 1'b1;
    smp();
    chk("bp_release_cycle", {29'd0, rd1[0], rd0[0], rv0[0]}, 32'd1);
    nxt(); smp();
    chk("bp_next_accept", {29'd0, rd1[0], rd0[0], bsy[0]}, 32'b100);
    nxt();
    v0[0] = 1'b0; v1[0] = 1'b0;
    c = 0;
    smp();
    while (rv1[0] !== 1'b1 && c < 20) begin nxt(); smp(); c++; end
    chk("bp_p1_rsp", {16'd0, p1[0]}, 32'h003F);
    nxt();
    wait_idle(0);

    // Reset during CALC aborts the operation.
    v0[0] = 1'b1; a0[0] = 16'd2; b0[0] = 16'd2;
    smp();
    chk("abort_accept", {30'd0, rd1[0], rd0[0]}, 32'd1);
    nxt();
    v0[0] = 1'b0;
    rst_n = 1'b0;
    smp();
    chk("abort_during", {29'd0, bsy[0], rv1[0], rv0[0]}, 32'd0);
    nxt(); smp();
    chk("abort_after", {29'd0, bsy[0], rv1[0], rv0[0]}, 32'd0);
    chk("abort_result", {16'd0, p0[0]}, 32'd0);
    nxt();
    rst_n = 1'b1;

    // Contention: both ports request continuously, port 0 first after reset.
    v0[0] = 1'b1; a0[0] = 16'd4; b0[0] = 16'd6;
    v1[0] = 1'b1; a1[0] = 16'd7; b1[0] = 16'd9;
    nacc = 0; nrsp = 0; last_acc = 0;
    for (int cy = 0; cy < 40; cy++) begin
      smp();
      if (rd0[0] || rd1[0]) begin
        acc_port = rd1[0] ? 1 : 0;
        chk("cont_grant", {30'd0, rd1[0], rd0[0]}, (nacc % 2 == 0) ? 32'd1 : 32'd2);
        if (nacc > 0) chk("cont_spacing", 32'(cy - last_acc), 32'd3);
        last_acc = cy;
        nacc++;
      end
      if (rv0[0] || rv1[0]) begin
        chk("cont_rsp_port", {30'd0, rv1[0], rv0[0]}, (nrsp % 2 == 0) ? 32'd1 : 32'd2);
        chk("cont_rsp_p", {16'd0, rv1[0] ? p1[0] : p0[0]},
            (nrsp % 2 == 0) ? 32'h0018 : 32'h003F);
        nrsp++;
      end
      nxt();
    end
    chk("cont_accepts", {31'd0, nacc >= 12}, 32'd1);
    chk("cont_responses", {31'd0, nrsp >= 12}, 32'd1);
    v0[0] = 1'b0; v1[0] = 1'b0;
    wait_idle(0);

    do_reset();
    rand_run(0, 1, 400);
    do_reset();
    rand_run(1, 4, 400);
    do_reset();
    rand_run(2, 1, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
